// File: rtl/clk_div_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : clk_div_ctrl_if
// Purpose  : Host configuration port and divided-clock status bundle.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface clk_div_ctrl_if #(
  parameter int W    = 8,
  parameter int NCH  = 3,
  parameter int CH_W = (NCH > 1) ? $clog2(NCH) : 1
);
  logic            cfg_valid;
  logic            cfg_ready;
  logic [CH_W-1:0] cfg_ch;
  logic [W-1:0]    cfg_half;
  logic            cfg_en;
  logic [NCH-1:0]  clk_out;
  logic [NCH-1:0]  tick;
  logic [NCH-1:0]  pend;
  logic [NCH-1:0]  active;

  modport master (
    output cfg_valid, cfg_ch, cfg_half, cfg_en,
    input  cfg_ready, clk_out, tick, pend, active
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_half, cfg_en,
    output cfg_ready, clk_out, tick, pend, active
  );
endinterface

`default_nettype wire

// File: rtl/clk_div_ctrl.sv
//------------------------------------------------------------------------------
// Module   : clk_div_ctrl
// Purpose  : NCH-channel 50%-duty clock divider with shadowed reconfiguration.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module clk_div_ctrl #(
  parameter int W   = 8,
  parameter int NCH = 3
) (
  input  logic           CLK_in,
  input  logic           RST,
  clk_div_ctrl_if.slave  bus
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    S_OFF      = 2'd0,
    S_RUN      = 2'd1,
    S_RUN_PEND = 2'd2
  } state_t;

  logic           w_ready;
  logic [W-1:0]   w_half_eff;
  logic [NCH-1:0] w_clk;
  logic [NCH-1:0] w_tick;
  logic [NCH-1:0] w_pend;
  logic [NCH-1:0] w_active;

  // Out-of-range channel numbers stay ready so the host never stalls on them.
  always_comb begin
    w_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (bus.cfg_ch == CH_W'(i)) begin
        w_ready = !w_pend[i];
      end
    end
  end

  assign w_half_eff    = (bus.cfg_half == '0) ? W'(1) : bus.cfg_half;
  assign bus.cfg_ready = w_ready;
  assign bus.clk_out   = w_clk;
  assign bus.tick      = w_tick;
  assign bus.pend      = w_pend;
  assign bus.active    = w_active;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    state_t       r_state;
    logic [W-1:0] r_cnt;
    logic [W-1:0] r_half_act;
    logic [W-1:0] r_half_sh;
    logic         r_en_sh;
    logic         r_clk;
    logic         r_tick;
    logic         w_acc;
    logic         w_wrap;

    assign w_acc  = bus.cfg_valid && w_ready && (bus.cfg_ch == CH_W'(gi));
    assign w_wrap = (r_cnt == (r_half_act - W'(1)));

    always_ff @(posedge CLK_in or posedge RST) begin
      if (RST) begin
        r_state    <= S_OFF;
        r_cnt      <= '0;
        r_half_act <= W'(1);
        r_half_sh  <= '0;
        r_en_sh    <= 1'b0;
        r_clk      <= 1'b0;
        r_tick     <= 1'b0;
      end else begin
        r_tick <= 1'b0;
        case (r_state)
          S_OFF: begin
            r_clk <= 1'b0;
            r_cnt <= '0;
            if (w_acc) begin
              r_half_act <= w_half_eff;
              if (bus.cfg_en) begin
                r_state <= S_RUN;
              end
            end
          end
          S_RUN, S_RUN_PEND: begin
            if (w_wrap) begin
              r_cnt  <= '0;
              r_clk  <= !r_clk;
              r_tick <= 1'b1;
              // Shadow lands only on the falling edge so every period is whole.
              if ((r_state == S_RUN_PEND) && r_clk) begin
                if (r_en_sh) begin
                  r_half_act <= r_half_sh;
                  r_state    <= S_RUN;
                end else begin
                  r_state    <= S_OFF;
                end
              end
            end else begin
              r_cnt <= r_cnt + W'(1);
            end
            if ((r_state == S_RUN) && w_acc) begin
              r_half_sh <= w_half_eff;
              r_en_sh   <= bus.cfg_en;
              r_state   <= S_RUN_PEND;
            end
          end
          default: r_state <= S_OFF;
        endcase
      end
    end

    assign w_clk[gi]    = r_clk;
    assign w_tick[gi]   = r_tick;
    assign w_pend[gi]   = (r_state == S_RUN_PEND);
    assign w_active[gi] = (r_state != S_OFF);
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_clk_div_ctrl
// Purpose  : Directed vector table plus hand sequences for clk_div_ctrl.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_clk_div_ctrl;

  logic CLK_in = 1'b0;
  logic RST    = 1'b1;

  clk_div_ctrl_if #(.W(8), .NCH(3)) bus ();

  clk_div_ctrl #(.W(8), .NCH(3)) dut (
    .CLK_in (CLK_in),
    .RST    (RST),
    .bus    (bus)
  );

  always #5 CLK_in = ~CLK_in;

  typedef struct {
    logic       valid;
    logic [1:0] ch;
    logic [7:0] half;
    logic       en;
    logic [2:0] exp_clk;
    logic [2:0] exp_tick;
    logic [2:0] exp_act;
    logic [2:0] exp_pend;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs[17];

  function automatic vec_t mk(input logic v, input logic [1:0] ch, input logic [7:0] h,
                              input logic en, input logic [2:0] c, input logic [2:0] t,
                              input logic [2:0] a, input logic [2:0] p);
    vec_t r;
    r.valid = v; r.ch = ch; r.half = h; r.en = en;
    r.exp_clk = c; r.exp_tick = t; r.exp_act = a; r.exp_pend = p;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK_in);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] ch, input logic [7:0] h, input logic en);
    bus.cfg_valid = v;
    bus.cfg_ch    = ch;
    bus.cfg_half  = h;
    bus.cfg_en    = en;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_clk"},   {29'd0, bus.clk_out}, 32'd0);
    chk({name, "_tick"},  {29'd0, bus.tick},    32'd0);
    chk({name, "_pend"},  {29'd0, bus.pend},    32'd0);
    chk({name, "_act"},   {29'd0, bus.active},  32'd0);
    chk({name, "_ready"}, {31'd0, bus.cfg_ready}, 32'd1);
  endtask

  initial begin
    // Ch0 half=1 then ch1 half=5 on consecutive edges; ch1 rises 5 edges after acceptance.
    vecs[0]  = mk(1, 2'd0, 8'd1, 1, 3'b000, 3'b000, 3'b001, 3'b000);
    vecs[1]  = mk(1, 2'd1, 8'd5, 1, 3'b001, 3'b001, 3'b011, 3'b000);
    vecs[2]  = mk(0, 2'd0, 8'd0, 0, 3'b000, 3'b001, 3'b011, 3'b000);
    vecs[3]  = mk(0, 2'd0, 8'd0, 0, 3'b001, 3'b001, 3'b011, 3'b000);
    vecs[4]  = mk(0, 2'd0, 8'd0, 0, 3'b000, 3'b001, 3'b011, 3'b000);
    vecs[5]  = mk(0, 2'd0, 8'd0, 0, 3'b001, 3'b001, 3'b011, 3'b000);
    vecs[6]  = mk(0, 2'd0, 8'd0, 0, 3'b010, 3'b011, 3'b011, 3'b000);
    vecs[7]  = mk(0, 2'd0, 8'd0, 0, 3'b011, 3'b001, 3'b011, 3'b000);
    vecs[8]  = mk(0, 2'd0, 8'd0, 0, 3'b010, 3'b001, 3'b011, 3'b000);
    vecs[9]  = mk(0, 2'd0, 8'd0, 0, 3'b011, 3'b001, 3'b011, 3'b000);
    vecs[10] = mk(0, 2'd0, 8'd0, 0, 3'b010, 3'b001, 3'b011, 3'b000);
    vecs[11] = mk(0, 2'd0, 8'd0, 0, 3'b001, 3'b011, 3'b011, 3'b000);
    vecs[12] = mk(0, 2'd0, 8'd0, 0, 3'b000, 3'b001, 3'b011, 3'b000);
    vecs[13] = mk(0, 2'd0, 8'd0, 0, 3'b001, 3'b001, 3'b011, 3'b000);
    vecs[14] = mk(0, 2'd0, 8'd0, 0, 3'b000, 3'b001, 3'b011, 3'b000);
    vecs[15] = mk(0, 2'd0, 8'd0, 0, 3'b001, 3'b001, 3'b011, 3'b000);
    vecs[16] = mk(0, 2'd0, 8'd0, 0, 3'b010, 3'b011, 3'b011, 3'b000);

    drive(0, 2'd0, 8'd0, 0);
    #2;
    chk_idle("reset_hold");
    @(negedge CLK_in);
    RST = 1'b0;
    repeat (5) step();
    chk_idle("post_reset_static");

    @(negedge CLK_in);
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].valid, vecs[i].ch, vecs[i].half, vecs[i].en);
      step();
      chk($sformatf("vec%0d_clk", i),  {29'd0, bus.clk_out}, {29'd0, vecs[i].exp_clk});
      chk($sformatf("vec%0d_tick", i), {29'd0, bus.tick},    {29'd0, vecs[i].exp_tick});
      chk($sformatf("vec%0d_act", i),  {29'd0, bus.active},  {29'd0, vecs[i].exp_act});
      chk($sformatf("vec%0d_pend", i), {29'd0, bus.pend},    {29'd0, vecs[i].exp_pend});
    end

    // Stop ch1 (rose at E16, falls at E21): shadowed until that falling edge.
    drive(1, 2'd1, 8'd5, 0);
    #1;
    chk("stop_ready_free", {31'd0, bus.cfg_ready}, 32'd1);
    step();
    drive(0, 2'd1, 8'd0, 0);
    #1;
    chk("stop_ready_busy", {31'd0, bus.cfg_ready}, 32'd0);
    chk("stop_pend_set", {29'd0, bus.pend}, 32'b010);
    repeat (3) step();
    chk("stop_still_high", {31'd0, bus.clk_out[1]}, 32'd1);
    chk("stop_still_pend", {29'd0, bus.pend}, 32'b010);
    step();
    chk("stop_fall_clk",  {31'd0, bus.clk_out[1]}, 32'd0);
    chk("stop_fall_tick", {31'd0, bus.tick[1]},    32'd1);
    chk("stop_fall_act",  {31'd0, bus.active[1]},  32'd0);
    chk("stop_fall_pend", {31'd0, bus.pend[1]},    32'd0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("stopped_clk",  {31'd0, bus.clk_out[1]}, 32'd0);
      chk("stopped_tick", {31'd0, bus.tick[1]},    32'd0);
    end

    // half=0 on ch1 must behave as half=1.
    drive(1, 2'd1, 8'd0, 1);
    step();
    drive(0, 2'd0, 8'd0, 0);
    chk("h0_act", {31'd0, bus.active[1]}, 32'd1);
    chk("h0_clk_start", {31'd0, bus.clk_out[1]}, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("h0_clk%0d", k), {31'd0, bus.clk_out[1]}, 32'(k & 1));
      chk($sformatf("h0_tick%0d", k), {31'd0, bus.tick[1]}, 32'd1);
    end

    // Ch2 half=50 accepted at edge A.
    drive(1, 2'd2, 8'd50, 1);
    step();
    drive(0, 2'd0, 8'd0, 0);
    chk("c2_act", {31'd0, bus.active[2]}, 32'd1);
    repeat (49) step();
    chk("c2_low_a49", {31'd0, bus.clk_out[2]}, 32'd0);
    step();
    chk("c2_rise_a50", {31'd0, bus.clk_out[2]}, 32'd1);
    chk("c2_tick_a50", {31'd0, bus.tick[2]},    32'd1);
    repeat (9) step();
    drive(1, 2'd2, 8'd3, 1);
    #1;
    chk("c2_ready_free", {31'd0, bus.cfg_ready}, 32'd1);
    step();
    chk("c2_pend_a60", {31'd0, bus.pend[2]}, 32'd1);
    drive(1, 2'd2, 8'd7, 1);
    #1;
    chk("c2_ready_stall", {31'd0, bus.cfg_ready}, 32'd0);
    step();
    drive(1, 2'd0, 8'd0, 1);
    #1;
    chk("c0_ready_parallel", {31'd0, bus.cfg_ready}, 32'd1);
    step();
    chk("c0_pend_set", {31'd0, bus.pend[0]}, 32'd1);
    drive(1, 2'd3, 8'd9, 1);
    #1;
    chk("ch3_ready", {31'd0, bus.cfg_ready}, 32'd1);
    step();
    drive(0, 2'd0, 8'd0, 0);
    chk("ch3_no_effect_act", {29'd0, bus.active}, 32'b111);
    chk("ch3_no_effect_pend2", {31'd0, bus.pend[2]}, 32'd1);
    repeat (36) step();
    chk("c2_high_a99", {31'd0, bus.clk_out[2]}, 32'd1);
    chk("c2_pend_a99", {31'd0, bus.pend[2]},    32'd1);
    step();
    chk("c2_fall_clk",  {31'd0, bus.clk_out[2]}, 32'd0);
    chk("c2_fall_tick", {31'd0, bus.tick[2]},    32'd1);
    chk("c2_fall_pend", {31'd0, bus.pend[2]},    32'd0);
    chk("c2_fall_act",  {31'd0, bus.active[2]},  32'd1);
    chk("c0_pend_clear", {31'd0, bus.pend[0]},   32'd0);
    repeat (2) step();
    chk("c2_h3_low",  {31'd0, bus.clk_out[2]}, 32'd0);
    chk("c2_h3_notick", {31'd0, bus.tick[2]}, 32'd0);
    step();
    chk("c2_h3_rise", {31'd0, bus.clk_out[2]}, 32'd1);
    chk("c2_h3_rise_tick", {31'd0, bus.tick[2]}, 32'd1);
    repeat (2) step();
    chk("c2_h3_high", {31'd0, bus.clk_out[2]}, 32'd1);
    step();
    chk("c2_h3_fall", {31'd0, bus.clk_out[2]}, 32'd0);
    chk("c2_h3_fall_tick", {31'd0, bus.tick[2]}, 32'd1);

    // Pend ch2 during its high phase, then reset mid-cycle.
    repeat (2) step();
    drive(1, 2'd2, 8'd4, 1);
    step();
    chk("rst_pre_clk",  {31'd0, bus.clk_out[2]}, 32'd1);
    chk("rst_pre_pend", {31'd0, bus.pend[2]},    32'd1);
    drive(1, 2'd0, 8'd2, 1);
    #2;
    RST = 1'b1;
    #1;
    chk_idle("rst_async");
    repeat (2) step();
    chk("rst_cfg_ignored", {29'd0, bus.active}, 32'd0);
    drive(0, 2'd0, 8'd0, 0);
    @(negedge CLK_in);
    RST = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk_idle("rst_release");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
